// File: rtl/d5m_pkg.sv
// d5m_pkg: shared D5M pixel-interface types, shared by the pattern source and the capture side.
package d5m_pkg;

    typedef enum logic [2:0] {IDLE, FV_LEAD, LINE, HBLANK, FV_TRAIL, VBLANK} state_t;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_HRAMP = 2'd1;
    localparam logic [1:0] MODE_VRAMP = 2'd2;
    localparam logic [1:0] MODE_BARS  = 2'd3;

    // Bayer site indexed by {row[0], col[0]}
    typedef enum logic [1:0] {SITE_GR = 2'b00, SITE_R = 2'b01, SITE_B = 2'b10, SITE_GB = 2'b11} site_t;

    typedef logic [11:0] sample_t;

    function automatic sample_t bar_sample(input logic [2:0] bar, input site_t site);
        return {12{site == SITE_R ? bar[2] : site == SITE_B ? bar[0] : bar[1]}};
    endfunction

endpackage

// File: rtl/d5m_pattern_tx_pixel_gen.sv
// d5m_pixel_gen: registered test-pattern sample generator, fed with next-cycle coordinates
// so its output register lines up with the oLVAL register.
module d5m_pixel_gen
    import d5m_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        lval,
    input  logic [1:0]  mode,
    input  sample_t     cval,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [2:0]  bar,
    output sample_t     data
);

    sample_t data_n;

    always_comb
        data_n = !lval               ? 12'h000 :
                 mode == MODE_CONST  ? cval :
                 mode == MODE_HRAMP  ? {x, 1'b0} :
                 mode == MODE_VRAMP  ? {y, 1'b0} :
                 bar_sample(bar, site_t'({y[0], x[0]}));

    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) data <= '0;
        else      data <= data_n;

endmodule

// File: rtl/d5m_pattern_tx.sv
// d5m_pattern_tx: deterministic D5M-style raster source (FVAL/LVAL framing + 12-bit Bayer samples).
// Next-state values are computed combinationally so the sample generator sees them in step.
module d5m_pattern_tx
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 960,
    parameter int FV_TO_LV = 4,
    parameter int LV_TO_FV = 4,
    parameter int V_BLANK  = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iFreeRun,
    input  logic [1:0]  iMode,
    input  logic [11:0] iConst,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [11:0] oDATA,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic [15:0] oFrameCnt
);

    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] B_LAST = 11'(H_ACTIVE / 8 - 1);

    state_t      state, state_n;
    logic [15:0] tmr, tmr_n;
    logic [10:0] x_n, y_n, barc, barc_n;
    logic [2:0]  bar, bar_n;
    logic        fval_n, lval_n, busy_n, done_n, latch;
    logic [1:0]  mode;
    sample_t     cval;

    always_comb begin
        state_n = state;
        tmr_n   = tmr - 16'd1;
        x_n     = oX;
        y_n     = oY;
        barc_n  = barc;
        bar_n   = bar;
        fval_n  = oFVAL;
        lval_n  = oLVAL;
        busy_n  = oBusy;
        done_n  = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE:
                if (iStart || iFreeRun) begin
                    state_n = FV_LEAD;
                    tmr_n   = 16'(FV_TO_LV - 1);
                    fval_n  = 1'b1;
                    busy_n  = 1'b1;
                    latch   = 1'b1;
                end
            FV_LEAD:
                if (tmr == 16'd0) begin
                    state_n = LINE;
                    lval_n  = 1'b1;
                    x_n     = '0;
                    barc_n  = '0;
                    bar_n   = '0;
                end
            LINE:
                if (oX == X_LAST) begin
                    state_n = HBLANK;
                    lval_n  = 1'b0;
                    x_n     = '0;
                    tmr_n   = 16'(H_BLANK - 1);
                end else begin
                    x_n    = oX + 11'd1;
                    barc_n = barc == B_LAST ? 11'd0 : barc + 11'd1;
                    bar_n  = barc == B_LAST ? bar + 3'd1 : bar;
                end
            HBLANK:
                if (tmr == 16'd0) begin
                    if (oY != Y_LAST) begin
                        state_n = LINE;
                        lval_n  = 1'b1;
                        y_n     = oY + 11'd1;
                        x_n     = '0;
                        barc_n  = '0;
                        bar_n   = '0;
                    end else begin
                        state_n = FV_TRAIL;
                        tmr_n   = 16'(LV_TO_FV - 1);
                    end
                end
            FV_TRAIL:
                if (tmr == 16'd0) begin
                    state_n = VBLANK;
                    fval_n  = 1'b0;
                    done_n  = 1'b1;
                    y_n     = '0;
                    tmr_n   = 16'(V_BLANK - 1);
                end
            VBLANK:
                if (tmr == 16'd0) begin
                    if (iFreeRun) begin
                        state_n = FV_LEAD;
                        tmr_n   = 16'(FV_TO_LV - 1);
                        fval_n  = 1'b1;
                        latch   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST)
        if (iRST) begin
            state      <= IDLE;
            tmr        <= '0;
            oX         <= '0;
            oY         <= '0;
            barc       <= '0;
            bar        <= '0;
            oFVAL      <= 1'b0;
            oLVAL      <= 1'b0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
            oFrameCnt  <= '0;
            mode       <= MODE_CONST;
            cval       <= '0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            oX         <= x_n;
            oY         <= y_n;
            barc       <= barc_n;
            bar        <= bar_n;
            oFVAL      <= fval_n;
            oLVAL      <= lval_n;
            oBusy      <= busy_n;
            oFrameDone <= done_n;
            if (done_n) oFrameCnt <= oFrameCnt + 16'd1;
            if (latch) begin
                mode <= iMode;
                cval <= iConst;
            end
        end

    d5m_pixel_gen u_pixel_gen (
        .iCLK (iCLK),
        .iRST (iRST),
        .lval (lval_n),
        .mode (mode),
        .cval (cval),
        .x    (x_n),
        .y    (y_n),
        .bar  (bar_n),
        .data (oDATA)
    );

endmodule

// File: tb/tb_d5m_pattern_tx.sv
// tb_d5m_pattern_tx: directed checks of d5m_pattern_tx framing, pattern modes, start handling and counter wrap.
module tb_d5m_pattern_tx;

    localparam int H_ACTIVE = 16;
    localparam int H_BLANK  = 4;
    localparam int V_ACTIVE = 4;
    localparam int FV_TO_LV = 2;
    localparam int LV_TO_FV = 3;
    localparam int V_BLANK  = 5;
    localparam int FV_LEN   = FV_TO_LV + V_ACTIVE * (H_ACTIVE + H_BLANK) + LV_TO_FV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        free_run = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] cval = 12'd0;
    logic        fval, lval, busy, done;
    logic [11:0] data;
    logic [10:0] x, y;
    logic [15:0] cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    d5m_pattern_tx #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .FV_TO_LV(FV_TO_LV), .LV_TO_FV(LV_TO_FV), .V_BLANK(V_BLANK)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iStart     (start),
        .iFreeRun   (free_run),
        .iMode      (mode),
        .iConst     (cval),
        .oFVAL      (fval),
        .oLVAL      (lval),
        .oDATA      (data),
        .oX         (x),
        .oY         (y),
        .oBusy      (busy),
        .oFrameDone (done),
        .oFrameCnt  (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [1:0] m, input logic [11:0] c, input int px, input int py);
        logic [2:0] b;
        logic       on;
        b  = 3'(px / (H_ACTIVE / 8));
        on = (py % 2 == 0 && px % 2 == 1) ? b[2] :
             (py % 2 == 1 && px % 2 == 0) ? b[0] : b[1];
        case (m)
            2'd0:    return c;
            2'd1:    return 12'(px * 2);
            2'd2:    return 12'(py * 2);
            default: return on ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic start_frame(input logic [1:0] m, input logic [11:0] c);
        mode  = m;
        cval  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered on the first oFVAL=1 cycle; returns on the cycle oFVAL falls.
    task automatic watch_frame(input string tag, input logic [1:0] m, input logic [11:0] c, input bit poke);
        int fv = 0, lead = 0, ex = 0, ey = 0, run = 0, gap = 0, lines = 0, bad = 0;
        bit seen = 0, pl = 0;
        chk({tag, "_fval_rise"}, 32'(fval), 1);
        while (fval && fv < 400) begin
            fv++;
            if (done) bad++;
            if (lval) begin
                if (!seen) begin
                    seen = 1;
                    chk({tag, "_lead"}, lead, FV_TO_LV);
                end
                if (!pl && lines > 0 && gap != H_BLANK) bad++;
                if (32'(x) != ex || 32'(y) != ey) bad++;
                chk({tag, "_data"}, 32'(data), 32'(model(m, c, ex, ey)));
                ex++;
                run++;
            end else begin
                if (!seen) lead++;
                if (pl) begin
                    if (run != H_ACTIVE) bad++;
                    run = 0; ex = 0; ey++; lines++; gap = 0;
                end
                gap++;
                if (data != 12'd0) bad++;
            end
            pl = lval;
            start = poke && lval && ex == 4;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_fval_len"}, fv, FV_LEN);
        chk({tag, "_lines"}, lines, V_ACTIVE);
        chk({tag, "_framing"}, bad, 0);
        chk({tag, "_done_pulse"}, 32'(done), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int act = 0;
        for (int i = 0; i < cycles; i++) begin
            if (fval || lval || busy) act++;
            @(negedge clk);
        end
        chk({tag, "_quiet"}, act, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fval", 32'(fval), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        rst = 1'b0;
        quiet("post_rst", 8);

        // horizontal ramp, single frame, oBusy drops exactly after V_BLANK
        start_frame(2'd1, 12'h000);
        watch_frame("hramp", 2'd1, 12'h000, 0);
        chk("hramp_cnt", 32'(cnt), 1);
        repeat (V_BLANK - 1) @(negedge clk);
        chk("hramp_busy_last_vblank", 32'(busy), 1);
        @(negedge clk);
        chk("hramp_busy_after", 32'(busy), 0);
        chk("hramp_done_clear", 32'(done), 0);

        // colour bars
        start_frame(2'd3, 12'h000);
        watch_frame("bars", 2'd3, 12'h000, 0);
        chk("bars_cnt", 32'(cnt), 2);
        wait_idle("bars");

        // asynchronous reset in the middle of a line
        start_frame(2'd1, 12'h000);
        for (int i = 0; i < 40 && !lval; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pre_rst_lval", 32'(lval), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_fval", 32'(fval), 0);
        chk("midrst_lval", 32'(lval), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_data", 32'(data), 0);
        chk("midrst_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        quiet("midrst", 12);

        // starts during LINE and VBLANK are ignored
        start_frame(2'd1, 12'h000);
        watch_frame("ignore", 2'd1, 12'h000, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_cnt", 32'(cnt), 1);
        wait_idle("ignore");
        quiet("ignore", 20);
        chk("ignore_cnt_final", 32'(cnt), 1);

        // free-run: mode change mid-frame lands on the next frame
        mode     = 2'd0;
        cval     = 12'hABC;
        free_run = 1'b1;
        @(negedge clk);
        mode = 2'd2;
        watch_frame("free1", 2'd0, 12'hABC, 0);
        begin
            int low = 0;
            while (!fval && low < 50) begin
                low++;
                @(negedge clk);
            end
            chk("free_vblank_len", low, V_BLANK);
        end
        free_run = 1'b0;
        watch_frame("free2", 2'd2, 12'hABC, 0);
        chk("free_cnt", 32'(cnt), 3);
        wait_idle("free");

        // frame counter wrap
        force dut.oFrameCnt = 16'hFFFF;
        #1 release dut.oFrameCnt;
        @(negedge clk);
        chk("wrap_preset", 32'(cnt), 32'hFFFF);
        start_frame(2'd0, 12'h5A5);
        watch_frame("wrap", 2'd0, 12'h5A5, 0);
        chk("wrap_cnt", 32'(cnt), 0);
        @(negedge clk);
        chk("wrap_done_once", 32'(done), 0);
        wait_idle("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
